// File: rtl/qspi_seq_controller.sv
// qspi_seq_controller: sequences one user command through the spi_cmd engine,
// optionally preceded by Write-Enable (06h) and followed by Read-Status (05h)
// polling until WIP clears or POLL_MAX polls have been spent.
// Ports: clk/reset (sync, active-high); trigger + request fields (quad,
//   wren_pre, poll_after, data_in_count, data_out_count, data_in);
//   results readout/status/busy/error; engine side eng_trigger, eng_quad,
//   eng_in_count, eng_out_count, eng_data_in (out) and eng_busy, eng_data_out (in).
// Optional macro QSPI_POLL_GAP_EN: inserts POLL_GAP idle cycles between polls.
module qspi_seq_controller #(
  parameter int MAXCMD   = 259,
  parameter int READ_W   = 64,
  parameter int POLL_MAX = 1000000,
  parameter int WIP_BIT  = 0,
  parameter int POLL_GAP = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  quad,
  input  logic                  wren_pre,
  input  logic                  poll_after,
  input  logic [11:0]           data_in_count,
  input  logic [11:0]           data_out_count,
  input  logic [MAXCMD*8-1:0]   data_in,
  output logic [READ_W-1:0]     readout,
  output logic [7:0]            status,
  output logic                  busy,
  output logic                  error,
  output logic                  eng_trigger,
  output logic                  eng_quad,
  output logic [11:0]           eng_in_count,
  output logic [11:0]           eng_out_count,
  output logic [MAXCMD*8-1:0]   eng_data_in,
  input  logic                  eng_busy,
  input  logic [63:0]           eng_data_out
);

  localparam int DW  = MAXCMD * 8;
  localparam int PCW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_RST_WAIT, S_IDLE, S_CHECK, S_WREN, S_WREN_WAIT, S_CMD, S_CMD_WAIT,
    S_POLL, S_POLL_WAIT, S_GAP, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic          req_quad, req_wren, req_poll;
  logic [11:0]   req_in_count, req_out_count;
  logic [DW-1:0] req_data;

  logic [PCW-1:0] poll_cnt, poll_cnt_inc;
  logic           eng_done, count_bad, wip, timeout;

  // Next engine drive values, decoded from state
  logic          trig_d, quad_d;
  logic [11:0]   in_d, out_d;
  logic [DW-1:0] data_d;

  // The pulse cycle itself is excluded: the engine may not have raised
  // eng_busy yet when it sees our trigger.
  assign eng_done     = !eng_trigger && !eng_busy;
  assign count_bad    = (req_in_count == 12'd0) || (req_in_count > 12'(MAXCMD)) ||
                        (req_out_count > 12'd8);
  assign wip          = eng_data_out[WIP_BIT];
  // Saturating increment; the counter never wraps.
  assign poll_cnt_inc = (poll_cnt == PCW'(POLL_MAX)) ? poll_cnt : poll_cnt + PCW'(1);
  assign timeout      = (poll_cnt_inc == PCW'(POLL_MAX));

`ifdef QSPI_POLL_GAP_EN
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  logic [GCW-1:0] gap_cnt;
  logic           gap_last;
  assign gap_last = (gap_cnt >= GCW'(POLL_GAP - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST_WAIT;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST_WAIT:  if (!eng_busy) state_nxt = S_IDLE;
      S_IDLE:      if (trigger) state_nxt = S_CHECK;
      // Counts are validated from the latched copy, one cycle after accept.
      S_CHECK:     state_nxt = count_bad ? S_DONE : (req_wren ? S_WREN : S_CMD);
      S_WREN:      state_nxt = S_WREN_WAIT;
      S_WREN_WAIT: if (eng_done) state_nxt = S_CMD;
      S_CMD:       state_nxt = S_CMD_WAIT;
      S_CMD_WAIT:  if (eng_done) state_nxt = req_poll ? S_POLL : S_DONE;
      S_POLL:      state_nxt = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (eng_done) begin
          if (!wip || timeout) state_nxt = S_DONE;
`ifdef QSPI_POLL_GAP_EN
          else state_nxt = S_GAP;
`else
          else state_nxt = S_POLL;
`endif
        end
      end
`ifdef QSPI_POLL_GAP_EN
      S_GAP:       if (gap_last) state_nxt = S_POLL;
`endif
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_RST_WAIT;
    endcase
  end

  // Output decode: engine values are only changed in issuing states so they
  // hold steady between pulses.
  always_comb begin
    trig_d = 1'b0;
    quad_d = eng_quad;
    in_d   = eng_in_count;
    out_d  = eng_out_count;
    data_d = eng_data_in;
    case (state)
      S_WREN: begin
        trig_d = 1'b1; quad_d = 1'b0; in_d = 12'd1; out_d = 12'd0;
        data_d = {8'h06, {(DW-8){1'b0}}};
      end
      S_CMD: begin
        trig_d = 1'b1; quad_d = req_quad; in_d = req_in_count;
        out_d  = req_out_count; data_d = req_data;
      end
      S_POLL: begin
        trig_d = 1'b1; quad_d = 1'b0; in_d = 12'd1; out_d = 12'd1;
        data_d = {8'h05, {(DW-8){1'b0}}};
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b1;
      error         <= 1'b0;
      readout       <= '0;
      status        <= '0;
      eng_trigger   <= 1'b0;
      eng_quad      <= 1'b0;
      eng_in_count  <= '0;
      eng_out_count <= '0;
      eng_data_in   <= '0;
      poll_cnt      <= '0;
      req_quad      <= 1'b0;
      req_wren      <= 1'b0;
      req_poll      <= 1'b0;
      req_in_count  <= '0;
      req_out_count <= '0;
      req_data      <= '0;
    end else begin
      busy          <= (state_nxt != S_IDLE);
      eng_trigger   <= trig_d;
      eng_quad      <= quad_d;
      eng_in_count  <= in_d;
      eng_out_count <= out_d;
      eng_data_in   <= data_d;
      if (state == S_IDLE && trigger) begin
        req_quad      <= quad;
        req_wren      <= wren_pre;
        req_poll      <= poll_after;
        req_in_count  <= data_in_count;
        req_out_count <= data_out_count;
        req_data      <= data_in;
        error         <= 1'b0;
      end
      if (state == S_CHECK && count_bad) error <= 1'b1;
      if (state == S_CMD_WAIT && eng_done) begin
        readout  <= eng_data_out[READ_W-1:0];
        poll_cnt <= '0;
      end
      if (state == S_POLL_WAIT && eng_done) begin
        status   <= eng_data_out[7:0];
        poll_cnt <= poll_cnt_inc;
        if (wip && timeout) error <= 1'b1;
      end
    end
  end

`ifdef QSPI_POLL_GAP_EN
  always_ff @(posedge clk) begin
    if (reset)               gap_cnt <= '0;
    else if (state != S_GAP) gap_cnt <= '0;
    else                     gap_cnt <= gap_cnt + GCW'(1);
  end
`endif

endmodule

// File: tb/tb_qspi_seq_controller.sv
// Directed bench for qspi_seq_controller with a behavioural spi_cmd engine
// that stays busy ENG_LAT cycles per pulse and returns queued status bytes.
module tb_qspi_seq_controller;
  localparam int MAXCMD   = 259;
  localparam int DW       = MAXCMD * 8;
  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 16;
  localparam int ENG_LAT  = 3;
`ifdef QSPI_POLL_GAP_EN
  localparam int EXP_SPACING = 21;  // 3 busy + 1 wait exit + 16 gap + 1 issue
`else
  localparam int EXP_SPACING = 5;   // 3 busy + 1 wait exit + 1 issue
`endif

  logic          clk = 1'b0;
  logic          reset, trigger, quad, wren_pre, poll_after;
  logic [11:0]   data_in_count, data_out_count;
  logic [DW-1:0] data_in;
  logic [63:0]   readout;
  logic [7:0]    status;
  logic          busy, error, eng_trigger, eng_quad;
  logic [11:0]   eng_in_count, eng_out_count;
  logic [DW-1:0] eng_data_in;
  logic          eng_busy = 1'b1;
  logic [63:0]   eng_data_out = '0;

  qspi_seq_controller #(.MAXCMD(MAXCMD), .READ_W(64), .POLL_MAX(POLL_MAX),
                        .WIP_BIT(0), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .quad(quad),
    .wren_pre(wren_pre), .poll_after(poll_after),
    .data_in_count(data_in_count), .data_out_count(data_out_count),
    .data_in(data_in), .readout(readout), .status(status), .busy(busy),
    .error(error), .eng_trigger(eng_trigger), .eng_quad(eng_quad),
    .eng_in_count(eng_in_count), .eng_out_count(eng_out_count),
    .eng_data_in(eng_data_in), .eng_busy(eng_busy), .eng_data_out(eng_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model and pulse log
  logic [7:0]  pulse_op[$];
  int          pulse_cyc[$];
  logic [11:0] pulse_in[$], pulse_out[$];
  logic        pulse_quad[$];
  logic [63:0] pulse_lo[$];
  logic [7:0]  status_q[$];
  logic [7:0]  default_status = 8'h01;
  logic [63:0] cmd_resp = '0;
  logic [63:0] pend_resp = '0;
  int          eng_cnt = 6;
  int          idle_cyc = 0;

  always @(negedge clk) begin
    if (eng_trigger === 1'b1) begin
      pulse_op.push_back(eng_data_in[DW-1 -: 8]);
      pulse_cyc.push_back(cyc);
      pulse_in.push_back(eng_in_count);
      pulse_out.push_back(eng_out_count);
      pulse_quad.push_back(eng_quad);
      pulse_lo.push_back(eng_data_in[63:0]);
      if (eng_data_in[DW-1 -: 8] == 8'h05) begin
        if (status_q.size() > 0) pend_resp = {56'd0, status_q.pop_front()};
        else                     pend_resp = {56'd0, default_status};
      end else begin
        pend_resp = cmd_resp;
      end
      eng_busy = 1'b1;
      eng_cnt  = ENG_LAT;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_busy     = 1'b0;
        eng_data_out = pend_resp;
        idle_cyc     = cyc;
      end
    end
  end

  int trig_cyc = 0;

  task automatic start_cmd(input logic q, input logic w, input logic p,
                           input logic [11:0] ic, input logic [11:0] oc,
                           input logic [DW-1:0] d);
    @(negedge clk);
    quad = q; wren_pre = w; poll_after = p;
    data_in_count = ic; data_out_count = oc; data_in = d;
    trigger = 1'b1; trig_cyc = cyc;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(output int low_cyc);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
    low_cyc = cyc;
  endtask

  logic [DW-1:0] d, pp;
  int t, base, n, npoll;
  logic [11:0] bad_in[3]  = '{12'd0, 12'd260, 12'd1};
  logic [11:0] bad_out[3] = '{12'd0, 12'd0, 12'd9};

  initial begin
    reset = 1'b1; trigger = 1'b0; quad = 1'b0; wren_pre = 1'b0; poll_after = 1'b0;
    data_in_count = '0; data_out_count = '0; data_in = '0;

    // Reset values while the engine is still busy from power-up
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_readout", readout, 64'd0);
    check("rst_trig", {63'd0, eng_trigger}, 64'd0);
    check("rst_counts", {40'd0, eng_in_count, eng_out_count}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rwait_busy", {63'd0, busy}, 64'd1);
    wait_idle(t);
    check("rwait_lag", 64'(t - idle_cyc), 64'd1);

    // Read-ID
    cmd_resp = 64'hEF4018; base = pulse_op.size();
    d = '0; d[DW-1 -: 8] = 8'h9F;
    start_cmd(1'b0, 1'b0, 1'b0, 12'd1, 12'd3, d);
    wait_idle(t);
    check("rid_pulses", 64'(pulse_op.size() - base), 64'd1);
    check("rid_op", {56'd0, pulse_op[base]}, 64'h9F);
    check("rid_counts", {40'd0, pulse_in[base], pulse_out[base]}, {40'd0, 12'd1, 12'd3});
    check("rid_latency", 64'(pulse_cyc[base] - trig_cyc), 64'd3);
    check("rid_readout", readout, 64'hEF4018);
    check("rid_error", {63'd0, error}, 64'd0);
    check("rid_busy_lag", 64'(t - idle_cyc), 64'd2);

    // Invalid counts: no engine traffic, busy for exactly two cycles
    for (int k = 0; k < 3; k++) begin
      base = pulse_op.size();
      start_cmd(1'b0, 1'b0, 1'b0, bad_in[k], bad_out[k], d);
      n = 0;
      while (busy && n < 20) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("inv%0d_busy", k), 64'(n), 64'd2);
      check($sformatf("inv%0d_error", k), {63'd0, error}, 64'd1);
      check($sformatf("inv%0d_pulses", k), 64'(pulse_op.size() - base), 64'd0);
    end

    // Boundary: 8 read bytes is legal, error cleared by new accept
    cmd_resp = 64'h0102030405060708; base = pulse_op.size();
    d = '0; d[DW-1 -: 8] = 8'h4B;
    start_cmd(1'b0, 1'b0, 1'b0, 12'd1, 12'd8, d);
    wait_idle(t);
    check("b8_error", {63'd0, error}, 64'd0);
    check("b8_out", {52'd0, pulse_out[base]}, 64'd8);
    check("b8_readout", readout, 64'h0102030405060708);

    // Page program: WREN, full 259-byte quad command, three polls
    for (int i = 0; i < MAXCMD; i++) pp[DW-1-8*i -: 8] = 8'(i * 7 + 1);
    pp[DW-1 -: 32] = 32'h02001000;
    cmd_resp = 64'hA5A5; base = pulse_op.size();
    status_q = '{8'h03, 8'h03, 8'h00}; default_status = 8'hFF;
    start_cmd(1'b1, 1'b1, 1'b1, 12'd259, 12'd0, pp);
    repeat (4) @(negedge clk);
    trigger = 1'b1;  // must be ignored while busy
    @(negedge clk);
    trigger = 1'b0;
    wait_idle(t);
    check("pp_pulses", 64'(pulse_op.size() - base), 64'd5);
    check("pp_ops", {24'd0, pulse_op[base], pulse_op[base+1], pulse_op[base+2],
                     pulse_op[base+3], pulse_op[base+4]}, 64'h0602050505);
    check("pp_wren", {pulse_lo[base][39:0], pulse_in[base], pulse_out[base]},
          {40'd0, 12'd1, 12'd0});
    check("pp_cmd_cnt", {51'd0, pulse_quad[base+1], pulse_in[base+1]}, {51'd0, 1'b1, 12'd259});
    check("pp_cmd_data", pulse_lo[base+1], pp[63:0]);
    check("pp_poll", {51'd0, pulse_quad[base+2], pulse_out[base+2]}, 64'd1);
    check("pp_spacing", 64'(pulse_cyc[base+4] - pulse_cyc[base+3]), 64'(EXP_SPACING));
    check("pp_status", {56'd0, status}, 64'h00);
    check("pp_error", {63'd0, error}, 64'd0);
    check("pp_readout", readout, 64'hA5A5);

    // Poll timeout: status stuck at 01h
    default_status = 8'h01; cmd_resp = 64'h77; base = pulse_op.size();
    d = '0; d[DW-1 -: 8] = 8'h20;
    start_cmd(1'b0, 1'b0, 1'b1, 12'd4, 12'd0, d);
    wait_idle(t);
    npoll = 0;
    for (int i = base; i < pulse_op.size(); i++) if (pulse_op[i] == 8'h05) npoll++;
    check("to_polls", 64'(npoll), 64'd4);
    check("to_error", {63'd0, error}, 64'd1);
    check("to_status", {56'd0, status}, 64'h01);
    check("to_readout", readout, 64'h77);

    // Reset while a poll is in flight
    cmd_resp = 64'h1234;
    start_cmd(1'b0, 1'b0, 1'b1, 12'd1, 12'd0, d);
    n = 0;
    while (!(eng_trigger && eng_data_in[DW-1 -: 8] == 8'h05) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rp_poll_seen", {63'd0, eng_trigger}, 64'd1);
    check("rp_readout_pre", readout, 64'h1234);
    reset = 1'b1;
    @(negedge clk);
    check("rp_trig", {63'd0, eng_trigger}, 64'd0);
    check("rp_busy", {63'd0, busy}, 64'd1);
    check("rp_readout", readout, 64'd0);
    check("rp_status", {56'd0, status}, 64'd0);
    reset = 1'b0;
    base = pulse_op.size();
    wait_idle(t);
    check("rp_lag", 64'(t - idle_cyc), 64'd1);
    check("rp_no_pulse", 64'(pulse_op.size() - base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
